dram_result_uart_rx: RTL



---
 rtl/dram_test_pkg.sv | 16 +
 rtl/uart_byte_rx.sv | 112 +++++++++++
 rtl/dram_result_uart_rx.sv | 104 ++++++++++
 3 files changed

// File: rtl/dram_test_pkg.sv
// Shared definitions for the DRAM test result link (receiver and transmitter sides).
package dram_test_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned WORD_BYTES = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } byte_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-flop synchroniser plus byte FSM. Strobes are decoded at the sample cycle.
// Define UART_RX_PARITY_EN for 8E1 framing; default is 8N1.
module uart_byte_rx
   import dram_test_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rxd,
   output logic [DATA_BITS-1:0] byte_data,
   output logic                 byte_done,
   output logic                 byte_err,
   output logic                 start_seen
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   byte_state_e          r_state;
   logic [1:0]           r_sync;
   logic                 r_rxd_prev;
   logic [CNT_W-1:0]     r_cnt;
   logic [BIT_W-1:0]     r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bad;

   logic w_rxd_s;
   logic w_fall;
   logic w_tick;
   logic w_half;

   assign w_rxd_s = r_sync[1];
   assign w_fall  = r_rxd_prev & ~w_rxd_s;
   assign w_tick  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_half  = (r_cnt == CNT_W'(HALF - 1));

   assign byte_data  = r_shift;
   assign start_seen = (r_state == StIdle) && w_fall;
   assign byte_done  = (r_state == StStop) && w_tick && w_rxd_s && !r_par_bad;
`ifdef UART_RX_PARITY_EN
   // A parity failure already raised its error; the stop bit then only closes the frame.
   assign byte_err   = ((r_state == StStop) && w_tick && !w_rxd_s && !r_par_bad) ||
                       ((r_state == StParity) && w_tick && ((^r_shift) != w_rxd_s));
`else
   assign byte_err   = (r_state == StStop) && w_tick && !w_rxd_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync     <= 2'b11;
         r_rxd_prev <= 1'b1;
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_par_bad  <= 1'b0;
      end else begin
         r_sync     <= {r_sync[0], uart_rxd};
         r_rxd_prev <= w_rxd_s;
         r_cnt      <= r_cnt + CNT_W'(1);
         unique case (r_state)
            StIdle: begin
               r_cnt <= '0;
               if (w_fall) r_state <= StStart;
            end
            StStart: begin
               if (w_half) begin
                  r_cnt     <= '0;
                  r_bit     <= '0;
                  r_par_bad <= 1'b0;
                  r_state   <= w_rxd_s ? StIdle : StData;
               end
            end
            StData: begin
               if (w_tick) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                  r_bit   <= r_bit + BIT_W'(1);
                  if (r_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= StParity;
`else
                     r_state <= StStop;
`endif
                  end
               end
            end
            StParity: begin
               if (w_tick) begin
                  r_cnt     <= '0;
                  r_par_bad <= ((^r_shift) != w_rxd_s);
                  r_state   <= StStop;
               end
            end
            StStop: begin
               if (w_tick) begin
                  r_cnt   <= '0;
                  r_state <= (w_rxd_s || r_par_bad) ? StIdle : StBreak;
               end
            end
            StBreak: begin
               r_cnt <= '0;
               if (w_rxd_s) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: rtl/dram_result_uart_rx.sv
// DRAM result link receiver: pairs UART bytes into 16-bit words (high byte first) on valid/ready.
// Define UART_RX_PARITY_EN for 8E1 framing; default is 8N1.
module dram_result_uart_rx
   import dram_test_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 200_000_000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rxd,
   output logic [15:0] word_data,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        frame_err,
   output logic        overrun,
   output logic [15:0] word_cnt
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
   localparam int unsigned TMO_CYCLES   = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TMO_W        = $clog2(TMO_CYCLES);

   logic [DATA_BITS-1:0] w_byte_data;
   logic                 w_byte_done;
   logic                 w_byte_err;
   logic                 w_start_seen;
   logic                 w_accept;

   logic                 r_phase;
   logic [DATA_BITS-1:0] r_hi_byte;
   logic [TMO_W-1:0]     r_tmo_cnt;
   logic [15:0]          r_word_data;
   logic                 r_word_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic [15:0]          r_word_cnt;

   uart_byte_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_rx (
      .clk       (clk),
      .rst       (rst),
      .uart_rxd  (uart_rxd),
      .byte_data (w_byte_data),
      .byte_done (w_byte_done),
      .byte_err  (w_byte_err),
      .start_seen(w_start_seen)
   );

   assign w_accept   = r_word_valid && word_ready;
   assign word_data  = r_word_data;
   assign word_valid = r_word_valid;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign word_cnt   = r_word_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase      <= 1'b0;
         r_hi_byte    <= '0;
         r_tmo_cnt    <= '0;
         r_word_data  <= '0;
         r_word_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_word_cnt   <= '0;
      end else begin
         r_frame_err <= w_byte_err;
         if (w_accept) begin
            r_word_cnt   <= r_word_cnt + 16'd1;
            r_word_valid <= 1'b0;
         end
         if (w_byte_err) begin
            r_phase <= 1'b0;
         end else if (w_byte_done) begin
            if (!r_phase) begin
               r_hi_byte <= w_byte_data;
               r_phase   <= 1'b1;
               r_tmo_cnt <= '0;
            end else begin
               r_phase <= 1'b0;
               // Accept and reload in the same cycle is fine; only a stalled output drops.
               if (!r_word_valid || word_ready) begin
                  r_word_data  <= {r_hi_byte, w_byte_data};
                  r_word_valid <= 1'b1;
               end else begin
                  r_overrun <= 1'b1;
               end
            end
         end else if (r_phase) begin
            if (w_start_seen) begin
               r_tmo_cnt <= '0;
            end else if (r_tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
               r_phase <= 1'b0;
            end else begin
               r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
         end
      end
   end

endmodule
